// File: rtl/reg_array_rdata_issuer_if.sv
// reg_array_rdata_issuer_if: job control, SRAM read port and reg-array beat stream of the rdata issuer
interface reg_array_rdata_issuer_if #(parameter int DW = 8, parameter int AW = 10);
  logic START;
  logic [AW-1:0] BASE_ADDR;
  logic [7:0] NUM_GROUPS;
  logic [3:0] NUM_RDATA;
  logic REG_ARRAY_FULL;
  logic REC_RDATA;
  logic MEM_RD_EN;
  logic [AW-1:0] MEM_RADDR;
  logic [DW-1:0] MEM_RDATA;
  logic [DW-1:0] RDATA;
  logic RDATA_VLD;
  logic BUSY;
  logic DONE;
  modport slave(
    input START, BASE_ADDR, NUM_GROUPS, NUM_RDATA, REG_ARRAY_FULL, REC_RDATA, MEM_RDATA,
    output MEM_RD_EN, MEM_RADDR, RDATA, RDATA_VLD, BUSY, DONE
  );
  modport master(
    output START, BASE_ADDR, NUM_GROUPS, NUM_RDATA, REG_ARRAY_FULL, REC_RDATA, MEM_RDATA,
    input MEM_RD_EN, MEM_RADDR, RDATA, RDATA_VLD, BUSY, DONE
  );
endinterface

// File: rtl/reg_array_rdata_issuer.sv
// reg_array_rdata_issuer: issues grouped SRAM read bursts and forwards the returned words as a beat stream into the reg array
module reg_array_rdata_issuer #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic SYS_CLK,
  input  logic SYS_RST,
  reg_array_rdata_issuer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SPACE, ISSUE, COMMIT} state_t;
  state_t state;
  logic [AW-1:0] addr;
  logic [7:0] num_groups, grp;
  logic [3:0] num_rdata, beat;
  logic valid_d;
  logic [DW-1:0] rdata;
  assign bus.RDATA = rdata;
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state <= IDLE;
      addr <= '0;
      num_groups <= '0;
      num_rdata <= '0;
      grp <= '0;
      beat <= '0;
      valid_d <= 1'b0;
      rdata <= '0;
      bus.MEM_RD_EN <= 1'b0;
      bus.MEM_RADDR <= '0;
      bus.RDATA_VLD <= 1'b0;
      bus.BUSY <= 1'b0;
      bus.DONE <= 1'b0;
    end else begin
      bus.DONE <= 1'b0;
      valid_d <= bus.MEM_RD_EN;
      bus.RDATA_VLD <= valid_d;
      if (valid_d) rdata <= bus.MEM_RDATA;
      case (state)
        IDLE:
          if (bus.START && bus.NUM_RDATA != 4'd0) begin
            if (bus.NUM_GROUPS == 8'd0) bus.DONE <= 1'b1;
            else begin
              addr <= bus.BASE_ADDR;
              num_groups <= bus.NUM_GROUPS;
              num_rdata <= bus.NUM_RDATA;
              grp <= '0;
              bus.BUSY <= 1'b1;
              state <= SPACE;
            end
          end
        // full is only sampled here, which is never earlier than the cycle after a commit
        SPACE:
          if (!bus.REG_ARRAY_FULL) begin
            bus.MEM_RD_EN <= 1'b1;
            bus.MEM_RADDR <= addr;
            beat <= 4'd1;
            state <= ISSUE;
          end
        ISSUE:
          if (beat == num_rdata) begin
            bus.MEM_RD_EN <= 1'b0;
            addr <= bus.MEM_RADDR + 1'b1;
            state <= COMMIT;
          end else begin
            bus.MEM_RADDR <= bus.MEM_RADDR + 1'b1;
            beat <= beat + 4'd1;
          end
        COMMIT:
          if (bus.REC_RDATA) begin
            grp <= grp + 8'd1;
            bus.DONE <= (grp + 8'd1 == num_groups);
            bus.BUSY <= (grp + 8'd1 != num_groups);
            state <= (grp + 8'd1 == num_groups) ? IDLE : SPACE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_array_rdata_issuer.sv
// tb_reg_array_rdata_issuer: random jobs checked cycle by cycle against a timing plan derived from the group schedule
module tb_reg_array_rdata_issuer;
  localparam int MAXT = 2048;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cur_t = 0;
  int obs_first_rd, obs_done_t, obs_reads;
  bit exp_rd[MAXT], exp_vld[MAXT], exp_done[MAXT], exp_busy[MAXT];
  bit full_at[MAXT], rec_at[MAXT], allow[MAXT];
  logic [9:0] exp_addr[MAXT];
  logic [7:0] exp_dat[MAXT];
  reg_array_rdata_issuer_if #(.DW(8), .AW(10)) bus();
  reg_array_rdata_issuer #(.DW(8), .AW(10)) dut(.SYS_CLK(clk), .SYS_RST(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] word_of(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], a[5:0]} ^ 8'h5A;
  endfunction
  // SRAM model: data appears one cycle after the read enable, garbage otherwise
  always @(posedge clk) bus.MEM_RDATA <= bus.MEM_RD_EN ? word_of(bus.MEM_RADDR) : 8'($urandom);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cur_t, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, bus.MEM_RD_EN, 0);
    chk({tag, "_raddr"}, bus.MEM_RADDR, 0);
    chk({tag, "_rdata"}, bus.RDATA, 0);
    chk({tag, "_vld"}, bus.RDATA_VLD, 0);
    chk({tag, "_busy"}, bus.BUSY, 0);
    chk({tag, "_done"}, bus.DONE, 0);
  endtask
  task automatic run_job(input int base, input int g, input int n, input int hold, input int prob, input bit stray);
    int c, s, tend, st;
    logic [9:0] a;
    foreach (exp_rd[i]) begin
      exp_rd[i] = 0; exp_vld[i] = 0; exp_done[i] = 0; exp_busy[i] = 0;
      exp_addr[i] = '0; exp_dat[i] = '0; rec_at[i] = 0; allow[i] = 1;
      full_at[i] = (i <= hold) || (i < 1500 && $urandom_range(0, 99) < prob);
    end
    s = 0;
    if (n == 0) tend = 12;
    else if (g == 0) begin
      exp_done[1] = 1;
      tend = 6;
    end else begin
      s = 1;
      a = 10'(base);
      for (int gi = 0; gi < g; gi++) begin
        c = s;
        while (full_at[c]) c++;
        for (int b = 0; b < n; b++) begin
          exp_rd[c + 1 + b] = 1;
          exp_addr[c + 1 + b] = a;
          exp_vld[c + 3 + b] = 1;
          exp_dat[c + 3 + b] = word_of(a);
          a = a + 10'd1;
        end
        for (int i = c + n + 1; i <= c + n + 3; i++) allow[i] = 0;
        rec_at[c + n + 3] = 1;
        s = c + n + 4;
      end
      exp_done[s] = 1;
      for (int i = 1; i < s; i++) exp_busy[i] = 1;
      tend = s + 3;
    end
    st = (stray && s > 2) ? $urandom_range(2, s - 1) : -1;
    obs_first_rd = -1; obs_done_t = -1; obs_reads = 0;
    for (int t = 0; t <= tend; t++) begin
      cur_t = t;
      bus.START = (t == 0);
      bus.BASE_ADDR = 10'(base);
      bus.NUM_GROUPS = 8'(g);
      bus.NUM_RDATA = 4'(n);
      if (t == st) begin
        bus.START = 1'b1;
        bus.BASE_ADDR = 10'($urandom);
        bus.NUM_GROUPS = 8'($urandom_range(1, 9));
        bus.NUM_RDATA = 4'($urandom_range(1, 15));
      end
      bus.REG_ARRAY_FULL = full_at[t];
      bus.REC_RDATA = rec_at[t] | (stray && allow[t] && $urandom_range(0, 9) == 0);
      @(posedge clk);
      @(negedge clk);
      cur_t = t + 1;
      if (bus.MEM_RD_EN) begin
        obs_reads++;
        if (obs_first_rd < 0) obs_first_rd = t + 1;
      end
      if (bus.DONE && obs_done_t < 0) obs_done_t = t + 1;
      chk("rd_en", bus.MEM_RD_EN, exp_rd[t + 1]);
      chk("busy", bus.BUSY, exp_busy[t + 1]);
      chk("done", bus.DONE, exp_done[t + 1]);
      chk("vld", bus.RDATA_VLD, exp_vld[t + 1]);
      if (exp_rd[t + 1]) chk("raddr", bus.MEM_RADDR, exp_addr[t + 1]);
      if (exp_vld[t + 1]) chk("rdata", bus.RDATA, exp_dat[t + 1]);
    end
    bus.START = 1'b0;
    bus.REC_RDATA = 1'b0;
    bus.REG_ARRAY_FULL = 1'b0;
  endtask
  initial begin
    bus.START = 1'b0; bus.BASE_ADDR = '0; bus.NUM_GROUPS = '0; bus.NUM_RDATA = '0;
    bus.REG_ARRAY_FULL = 1'b0; bus.REC_RDATA = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("post_reset");
    run_job(10'h010, 1, 3, -1, 0, 0);
    chk("single_done_cycle", obs_done_t, 8);
    chk("single_first_rd", obs_first_rd, 2);
    chk("single_reads", obs_reads, 3);
    run_job($urandom_range(0, 1023), 4, 9, -1, 0, 0);
    chk("four_groups_reads", obs_reads, 36);
    run_job($urandom_range(0, 1023), 2, 3, 20, 0, 0);
    chk("backpressure_first_rd", obs_first_rd, 22);
    run_job($urandom_range(0, 1023), 3, 3, -1, 60, 0);
    run_job(10'h3FE, 1, 3, -1, 0, 0);
    chk("wrap_reads", obs_reads, 3);
    run_job($urandom_range(0, 1023), 0, 3, -1, 0, 0);
    chk("zero_groups_reads", obs_reads, 0);
    chk("zero_groups_done", obs_done_t, 1);
    run_job($urandom_range(0, 1023), 2, 0, -1, 0, 0);
    chk("zero_rdata_done", obs_done_t, -1);
    run_job($urandom_range(0, 1023), 3, 9, -1, 30, 1);
    // reset during the second beat of a 9-beat group
    bus.BASE_ADDR = 10'h155; bus.NUM_GROUPS = 8'd1; bus.NUM_RDATA = 4'd9; bus.START = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.START = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    cur_t = 3;
    chk("rst_pre_rd_en", bus.MEM_RD_EN, 1);
    chk("rst_pre_raddr", bus.MEM_RADDR, 10'h156);
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    obs_done_t = -1; obs_reads = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.DONE) obs_done_t = i;
      if (bus.MEM_RD_EN || bus.RDATA_VLD) obs_reads++;
    end
    chk("after_reset_done", obs_done_t, -1);
    chk("after_reset_activity", obs_reads, 0);
    run_job(10'h2A0, 2, 9, -1, 20, 0);
    chk("after_reset_job_reads", obs_reads, 18);
    for (int j = 0; j < 25; j++) begin
      int n;
      n = (j % 3 == 0) ? 3 : (j % 3 == 1) ? 9 : $urandom_range(1, 15);
      run_job($urandom_range(0, 1023), $urandom_range(1, 5), n, -1, $urandom_range(0, 70), 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_array_rdata_issuer.md
# reg_array_rdata_issuer

Transmit-side companion of the reg-array FIFO controller. It issues bursts of 3 or 9 consecutive reads to the feature SRAM bank and forwards the returned words as an `RDATA`/`RDATA_VLD` beat stream into the reg array. It starts a group only when the reg array has a free slot, and it waits for the receiver's group-commit pulse before starting the next group. It sits between the bank read port and the reg array, under control of the layer sequencer (`START`/`DONE`).

## Interface
- `DW`, 8: data word width.
- `AW`, 10: SRAM read address width.

- `SYS_CLK`  in  1  system clock; all logic is on the rising edge.
- `SYS_RST`  in  1  reset, asynchronous, active-high.
- `START`  in  1  one-cycle job start; ignored unless `BUSY`=0.
- `BASE_ADDR`  in  AW  first read address, latched on `START`.
- `NUM_GROUPS`  in  8  number of groups in the job, latched on `START`.
- `NUM_RDATA`  in  4  beats per group, latched on `START`. Legal values are 1–15; 3 and 9 are the ones used in practice.
- `REG_ARRAY_FULL`  in  1  reg-array FIFO full flag.
- `REC_RDATA`  in  1  receiver group-commit pulse.
- `MEM_RD_EN`  out  1  SRAM read enable, registered.
- `MEM_RADDR`  out  AW  SRAM read address, registered.
- `MEM_RDATA`  in  DW  SRAM read data, valid 1 cycle after `MEM_RD_EN`.
- `RDATA`  out  DW  data beat to the reg array, registered.
- `RDATA_VLD`  out  1  beat valid, registered.
- `BUSY`  out  1  job in progress.
- `DONE`  out  1  one-cycle pulse when the job completes.

## Operation
- Reset values: all outputs are 0. The FSM is in IDLE and all internal counters are 0.
- **IDLE**
  - On `START` with `NUM_RDATA`≠0, latch the inputs, set `BUSY`=1 and go to SPACE.
  - `START` with `NUM_GROUPS`=0: do not enter SPACE and issue no reads. Pulse `DONE` in the next cycle; `BUSY` stays 0.
  - `START` with `NUM_RDATA`=0: ignore it, no response.
- **SPACE**: when `REG_ARRAY_FULL`=0, go to ISSUE; otherwise hold. There is no timeout.
- **ISSUE**
  - Assert `MEM_RD_EN` for exactly `NUM_RDATA` consecutive cycles.
  - `MEM_RADDR` starts at the running address and increments by 1 per beat, wrapping modulo 2^AW.
  - The running address carries across groups; it is not reset per group.
  - After the last beat, go to COMMIT.
- **COMMIT**
  - Wait for `REC_RDATA`.
  - On `REC_RDATA`, increment the group counter. If the count reaches `NUM_GROUPS`, pulse `DONE`, clear `BUSY` and go to IDLE; otherwise go to SPACE.
  - A `REC_RDATA` pulse seen outside COMMIT is ignored.
- **Return path**
  - `MEM_RD_EN` is delayed one cycle to form an internal valid.
  - `RDATA_VLD` is that internal valid, registered. `RDATA` is `MEM_RDATA` registered under the same condition. `RDATA` holds its last value when `RDATA_VLD`=0.
- **Receiver-compatibility rules**
  - The receiver clears its beat counter in the commit cycle and drops any `RDATA_VLD` that arrives in that cycle.
  - The receiver drops a whole group if it commits while full.
  - To respect both, the issuer never starts a group before the previous commit has been observed. It samples `REG_ARRAY_FULL` no earlier than the cycle after `REC_RDATA`, when the receiver's updated write pointer is already visible.
- A `START` while `BUSY`=1 is ignored and does not disturb the latched parameters.
- `SYS_RST` asserted mid-job forces IDLE immediately, with all outputs 0. Beats still in flight are discarded and no `DONE` is produced.

## Timing
- Cycle numbering is relative to `START` sampled high at cycle 0.
- Cycle 1: in SPACE. If `REG_ARRAY_FULL`=0 at cycle 1, `MEM_RD_EN` is high for cycles 2 … 1+N, where N = `NUM_RDATA`.
- Latency from `MEM_RD_EN` to `RDATA_VLD` is 2 cycles, so `RDATA_VLD` is high for cycles 4 … 3+N.
- The receiver's `REC_RDATA` is expected at cycle 4+N, i.e. the cycle after the last `RDATA_VLD`.
- At cycle 5+N: if groups remain, the FSM is in SPACE and samples full; otherwise `DONE`=1 and `BUSY`=0 in that cycle.
- Group-to-group spacing with no back-pressure: first read of group k+1 is N+4 cycles after first read of group k.
- `BUSY` rises in cycle 1 and falls in the `DONE` cycle.

## Test plan
- **Single group, 3 beats**: `BASE_ADDR`=0x010, `NUM_GROUPS`=1, `NUM_RDATA`=3, full=0, receiver model attached.
  - `MEM_RADDR`=0x010..0x012 in cycles 2–4; `RDATA_VLD` in cycles 4–6 with the matching data.
  - `DONE` in cycle 8; no further reads.
- **Four groups, 9 beats**: `NUM_GROUPS`=4, `NUM_RDATA`=9.
  - Exactly 36 reads at consecutive addresses with 4 idle cycles between groups.
  - Receiver write pointer advances by 4; no dropped beat.
- **Back-pressure**: hold `REG_ARRAY_FULL`=1 from cycle 0 to 20 with `NUM_RDATA`=3.
  - No `MEM_RD_EN` before cycle 22; first read at cycle 22.
  - Later, set full=1 after the first commit: issue stalls until full=0.
- **Address wrap**: `BASE_ADDR`=0x3FE, AW=10, `NUM_RDATA`=3.
  - Addresses 0x3FE, 0x3FF, 0x000.
- **Illegal and overlapping starts**:
  - `NUM_GROUPS`=0 gives a `DONE` pulse only, with no reads.
  - `NUM_RDATA`=0 gives no response.
  - A `START` while busy does not change the address sequence.
- **Reset mid-burst**: assert `SYS_RST` during the 2nd beat of a 9-beat group.
  - All outputs are 0 within the reset cycle and no `DONE` is produced.
  - A new `START` afterwards runs normally from the new `BASE_ADDR`.
